// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/gnt/rvalid data-memory port
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_out,
  input  logic [31:0] M_rs2_data,
  output logic        M_stall,
  output logic        M_misaligned,
  output logic [31:0] M_ld_data,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] we_q, we_d, we_c;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wdata_c, ld_q, ld_d;
  logic [1:0] off_q, off_d;
  logic acc, is_b, is_h, start;
  always_comb begin
    is_b = M_funct3[1:0] == 2'b00;
    is_h = M_funct3[1:0] == 2'b01;
    acc = M_mem_read | M_mem_write;
    M_misaligned = state_q == IDLE && acc &&
                   (is_h ? M_alu_out[0] : !is_b && M_alu_out[1:0] != 2'b00);
    // reset also masks a start so dm_req drops at once even with MEM inputs held
    start = !rst && state_q == IDLE && acc && !M_misaligned;
    we_c = !M_mem_write ? 4'b0000 : is_b ? 4'b0001 << M_alu_out[1:0] :
           is_h ? 4'b0011 << M_alu_out[1:0] : 4'b1111;
    wdata_c = !M_mem_write ? 32'h0 : is_b ? {4{M_rs2_data[7:0]}} :
              is_h ? {2{M_rs2_data[15:0]}} : M_rs2_data;
    dm_req = start || state_q == REQ;
    dm_we = start ? we_c : state_q == REQ ? we_q : 4'b0000;
    dm_addr = start ? {M_alu_out[31:2], 2'b00} : addr_q;
    dm_wdata = start ? wdata_c : wdata_q;
    M_stall = start || state_q == REQ || state_q == WAIT;
    we_d = start ? we_c : we_q;
    addr_d = start ? {M_alu_out[31:2], 2'b00} : addr_q;
    wdata_d = start ? wdata_c : wdata_q;
    off_d = start ? M_alu_out[1:0] : off_q;
    // a zero byte-enable pattern marks the captured access as a load
    ld_d = state_q == WAIT && dm_rvalid && we_q == 4'b0000 ? dm_rdata >> {off_q, 3'b000} : ld_q;
    state_d = state_q == IDLE ? (start ? (dm_gnt ? WAIT : REQ) : IDLE) :
              state_q == REQ  ? (dm_gnt ? WAIT : REQ) :
              state_q == WAIT ? (dm_rvalid ? DONE : WAIT) : IDLE;
    M_ld_data = ld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 4'b0000;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      off_q <= 2'b00;
      ld_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      off_q <= off_d;
      ld_q <= ld_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks against a byte-lane memory reference model
module tb_mem_access_unit;
  logic clk = 0, rst = 1;
  logic M_mem_read = 0, M_mem_write = 0;
  logic [2:0] M_funct3 = 0;
  logic [31:0] M_alu_out = 0, M_rs2_data = 0;
  logic M_stall, M_misaligned, dm_req;
  logic [31:0] M_ld_data, dm_addr, dm_wdata;
  logic [3:0] dm_we;
  logic dm_gnt = 0, dm_rvalid = 0;
  logic [31:0] dm_rdata = 0;
  int checks = 0, failures = 0;
  logic [31:0] exp_ld = 0;
  logic [31:0] mem [logic [31:0]];

  mem_access_unit dut (
    .clk(clk), .rst(rst), .M_mem_read(M_mem_read), .M_mem_write(M_mem_write),
    .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
    .M_stall(M_stall), .M_misaligned(M_misaligned), .M_ld_data(M_ld_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  function automatic int sz(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] f, input logic [31:0] a);
    logic [3:0] m = 0;
    for (int i = 0; i < 4; i++) m[i] = (i >= int'(a[1:0])) && (i < int'(a[1:0]) + sz(f));
    return m;
  endfunction

  function automatic logic [31:0] repl(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz(f)) +: 8];
    return r;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    M_mem_read = 0; M_mem_write = 0; dm_gnt = 0; dm_rvalid = 0;
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] rs2,
                            input int gd, input int rv, input string nm);
    logic [3:0] ew;
    logic [31:0] ea, ewd, rdat, cur;
    ew = wr ? lanes(f3, a) : 4'b0000;
    ewd = wr ? repl(f3, rs2) : 32'h0;
    ea = {a[31:2], 2'b00};
    @(posedge clk); #1;
    M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_alu_out = a; M_rs2_data = rs2;
    dm_gnt = (gd == 0); dm_rvalid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
    @(negedge clk);
    checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, M_stall, M_misaligned, M_ld_data} !==
        {1'b1, ew, ea, ewd, 1'b1, 1'b0, exp_ld}) begin
      failures++;
      $display("FAIL %s start got req=%b we=%b addr=%h wd=%h stall=%b mis=%b ld=%h exp we=%b addr=%h wd=%h ld=%h",
               nm, dm_req, dm_we, dm_addr, dm_wdata, M_stall, M_misaligned, M_ld_data, ew, ea, ewd, exp_ld);
    end
    for (int k = 1; k <= gd; k++) begin
      @(posedge clk); #1;
      dm_gnt = (k == gd); dm_rvalid = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({dm_req, dm_we, dm_addr, dm_wdata, M_stall, M_ld_data} !== {1'b1, ew, ea, ewd, 1'b1, exp_ld}) begin
        failures++;
        $display("FAIL %s req_hold%0d got req=%b we=%b addr=%h wd=%h stall=%b ld=%h exp we=%b addr=%h wd=%h ld=%h",
                 nm, k, dm_req, dm_we, dm_addr, dm_wdata, M_stall, M_ld_data, ew, ea, ewd, exp_ld);
      end
    end
    for (int k = 0; k <= rv; k++) begin
      @(posedge clk); #1;
      dm_gnt = 0; dm_rvalid = (k == rv);
      rdat = (!wr && mem.exists(ea)) ? mem[ea] : $urandom;
      dm_rdata = rdat;
      @(negedge clk);
      checks++;
      if ({dm_req, M_stall, M_ld_data} !== {1'b0, 1'b1, exp_ld}) begin
        failures++;
        $display("FAIL %s wait%0d got req=%b stall=%b ld=%h exp req=0 stall=1 ld=%h",
                 nm, k, dm_req, M_stall, M_ld_data, exp_ld);
      end
    end
    if (wr) begin
      cur = mem.exists(ea) ? mem[ea] : 32'h0;
      for (int i = 0; i < 4; i++) if (ew[i]) cur[8*i +: 8] = ewd[8*i +: 8];
      mem[ea] = cur;
    end else begin
      mem[ea] = rdat;
      exp_ld = rdat >> (8 * int'(a[1:0]));
    end
    @(posedge clk); #1;
    dm_rvalid = 0; dm_rdata = $urandom;
    @(negedge clk);
    checks++;
    if ({dm_req, M_stall, M_ld_data} !== {1'b0, 1'b0, exp_ld}) begin
      failures++;
      $display("FAIL %s done got req=%b stall=%b ld=%h exp req=0 stall=0 ld=%h",
               nm, dm_req, M_stall, M_ld_data, exp_ld);
    end
  endtask

  task automatic check_misaligned(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input string nm);
    @(posedge clk); #1;
    M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_alu_out = a; M_rs2_data = $urandom;
    dm_gnt = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({M_misaligned, dm_req, M_stall, dm_we, M_ld_data} !== {1'b1, 1'b0, 1'b0, 4'b0000, exp_ld}) begin
        failures++;
        $display("FAIL %s cyc%0d got mis=%b req=%b stall=%b we=%b ld=%h exp mis=1 req=0 stall=0 we=0000 ld=%h",
                 nm, k, M_misaligned, dm_req, M_stall, dm_we, M_ld_data, exp_ld);
      end
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dm_req, dm_we, M_stall, M_misaligned, M_ld_data} !== 39'h0) begin
      failures++;
      $display("FAIL reset got req=%b we=%b stall=%b mis=%b ld=%h exp all zero",
               dm_req, dm_we, M_stall, M_misaligned, M_ld_data);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({dm_req, dm_we, M_stall, M_ld_data} !== 38'h0) begin
      failures++;
      $display("FAIL idle_after_reset got req=%b we=%b stall=%b ld=%h exp all zero",
               dm_req, dm_we, M_stall, M_ld_data);
    end
  endtask

  task automatic test_directed();
    run_access(0, 1, 3'b000, 32'h1003, 32'hAABBCCDD, 0, 0, "sb_1003");
    idle();
    mem[32'h2000] = 32'h11223344;
    run_access(1, 0, 3'b100, 32'h2002, 32'h0, 3, 1, "lbu_2002");
    checks++;
    if (M_ld_data !== 32'h00001122) begin
      failures++;
      $display("FAIL lbu_value got=%h exp=00001122", M_ld_data);
    end
    idle();
  endtask

  task automatic test_misaligned();
    check_misaligned(0, 1, 3'b001, 32'h3001, "sh_3001");
    check_misaligned(1, 0, 3'b010, 32'h3002, "lw_3002");
    check_misaligned(1, 0, 3'b111, 32'h3003, "illegal_f3_3003");
  endtask

  task automatic test_back_to_back();
    run_access(0, 1, 3'b010, 32'h4000, 32'h0000ABCD, 0, 0, "sw_4000");
    run_access(1, 0, 3'b010, 32'h4000, 32'h0, 0, 0, "lw_4000");
    checks++;
    if (M_ld_data !== 32'h0000ABCD) begin
      failures++;
      $display("FAIL lw_after_sw got=%h exp=0000abcd", M_ld_data);
    end
    run_access(1, 1, 3'b010, 32'h5000, 32'h12345678, 1, 1, "both_sw_5000");
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    M_mem_read = 1; M_mem_write = 0; M_funct3 = 3'b010; M_alu_out = 32'h6000; dm_gnt = 1;
    @(posedge clk); #1;
    dm_gnt = 0;
    #2 rst = 1;
    #1;
    exp_ld = 0;
    checks++;
    if ({dm_req, M_stall, M_ld_data} !== 34'h0) begin
      failures++;
      $display("FAIL reset_mid got req=%b stall=%b ld=%h exp all zero", dm_req, M_stall, M_ld_data);
    end
    @(posedge clk); #1;
    M_mem_read = 0; rst = 0; dm_rvalid = 1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    @(posedge clk); #1;
    dm_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({dm_req, M_stall, M_ld_data} !== 34'h0) begin
      failures++;
      $display("FAIL stray_rvalid got req=%b stall=%b ld=%h exp all zero", dm_req, M_stall, M_ld_data);
    end
    run_access(1, 0, 3'b101, 32'h2002, 32'h0, 1, 0, "lhu_after_reset");
    idle();
  endtask

  task automatic test_random();
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      f3 = 3'($urandom_range(0, 7));
      a = 32'h100 + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz(f3)) - 1);
      if (a % sz(f3) != 0) check_misaligned(rd, wr, f3, a, "rand_mis");
      else begin
        run_access(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        if ($urandom_range(0, 1) != 0) idle();
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit: turns load/store requests from the execute result into a request/grant/response transaction on the data-memory port, generates byte enables and lane-replicated store data, and returns the loaded word byte-shifted so that byte offset 0 lands at bit 0. It holds the pipeline until the transaction completes. Its load output feeds the MW pipeline register; sign/zero extension by funct3 is done later in the writeback stage.

## Interface
Parameters: none (32-bit datapath fixed).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- M_mem_read  in  1  the instruction in MEM is a load
- M_mem_write  in  1  the instruction in MEM is a store; wins if both are set
- M_funct3  in  3  width: 000/100 byte, 001/101 half, 010 word
- M_alu_out  in  32  effective byte address
- M_rs2_data  in  32  store data (unaligned, LSB-justified)
- M_stall  out  1  holds IF–MEM pipeline registers while high
- M_misaligned  out  1  combinational flag: access is misaligned and was not issued
- M_ld_data  out  32  registered load word, shifted right by 8*addr[1:0]
- dm_req  out  1  memory request valid
- dm_we  out  4  byte write enables (0000 = read)
- dm_addr  out  32  word address {addr[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  response valid (loads and stores); one per granted request
- dm_rdata  in  32  read data, valid with dm_rvalid

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- Access starts in IDLE when M_mem_read or M_mem_write is set and the access is aligned.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
  - Misaligned access: M_misaligned=1, no dm_req, M_stall=0, state stays IDLE.
- On start, capture dm_we, dm_addr, dm_wdata, and addr[1:0] into registers. In the start cycle, dm_* are driven combinationally from the inputs with dm_req=1.
  - dm_gnt=1 → WAIT; otherwise → REQ.
- REQ: dm_req=1 and dm_* stay stable (from the registers) until dm_gnt=1, then → WAIT.
- WAIT: dm_req=0. On dm_rvalid:
  - Loads: M_ld_data ← dm_rdata >> (8*offset).
  - → DONE.
- DONE: M_stall=0 for exactly one cycle so the pipeline advances. MEM inputs are ignored in this cycle (no re-issue). → IDLE.
- M_stall=1 in the IDLE start cycle and in REQ and WAIT; 0 otherwise.
- Byte enables:
  - SB: 0001<<off
  - SH: 0011<<off
  - SW: 1111
  - Loads: 0000
- Store data:
  - SB: {4{rs2[7:0]}}
  - SH: {2{rs2[15:0]}}
  - SW: rs2
  - Loads: 0
- Illegal funct3 (011, 11x) is treated as word width.

## Timing
- Reset values: state IDLE, M_ld_data=0, captured registers 0. With no request active: dm_req=0, dm_we=0, M_stall=0.
- Best-case latency: gnt in the start cycle (c0) and rvalid in c1 → DONE in c2. Stall is high in c0–c1 and the instruction leaves MEM at the end of c2.
- dm_req, once asserted, is never dropped and its fields never change before dm_gnt (except on reset).
- dm_rvalid in IDLE, REQ, or DONE is ignored. dm_rvalid in the same cycle as dm_gnt (the REQ→WAIT edge) is not accepted; responses are taken only in WAIT.
- M_ld_data holds its value through stores and idle cycles and changes only on a load response.
- Reset asserted mid-transaction: state → IDLE and dm_req → 0 immediately (async). Any later stray rvalid is ignored.
- Back-to-back accesses: after DONE, the next instruction may start in the following IDLE cycle, giving one issue per 3 cycles minimum.

## Test plan
- SB, addr 0x1003, rs2 0xAABBCCDD, gnt immediate → dm_we=1000, dm_wdata=0xDDDDDDDD, dm_addr=0x1000, stall high 2 cycles.
- LBU, addr 0x2002, gnt delayed 3 cycles, rdata 0x11223344 → dm_req stable for 4 cycles, M_ld_data=0x00001122, stall low only in DONE.
- SH at 0x3001 and LW at 0x3002 → M_misaligned=1, dm_req never asserted, M_stall=0.
- SW 0x0000ABCD at 0x4000, then an immediate LW of 0x4000 from a memory model → dm_we=1111, then read M_ld_data=0x0000ABCD; M_ld_data unchanged by the store.
- Reset pulse while in WAIT, then a stray dm_rvalid → dm_req=0, state IDLE, M_ld_data=0, no stall.
- Both M_mem_read and M_mem_write set, SW at 0x5000 → a write is issued (dm_we=1111), M_ld_data not updated.
